// File: rtl/range_match_engine.sv
// Streaming range classifier: each value is checked against a table of inclusive
// [lo,hi] ranges, LANES entries per cycle, stopping at the first matching group.
module range_match_engine #(
    parameter int DATA_WIDTH  = 64,
    parameter int RANGE_DEPTH = 256,
    parameter int LANES       = 4,
    parameter int COUNT_WIDTH = 32,
    localparam int RAW = (RANGE_DEPTH > 1) ? $clog2(RANGE_DEPTH) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cfg_we,
    input  logic [RAW-1:0]         cfg_addr,
    input  logic [DATA_WIDTH-1:0]  cfg_lo,
    input  logic [DATA_WIDTH-1:0]  cfg_hi,
    input  logic [RAW:0]           cfg_count,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_hit,
    output logic [RAW-1:0]         out_index,
    output logic [COUNT_WIDTH-1:0] hit_count,
    output logic                   busy,
    output logic                   done
);

    localparam logic [RAW:0] DEPTH_W = (RAW+1)'(RANGE_DEPTH);
    localparam logic [RAW:0] LANES_W = (RAW+1)'(LANES);

    typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;

    state_t state_q, state_d;

    logic [DATA_WIDTH-1:0]  lo_q [RANGE_DEPTH];
    logic [DATA_WIDTH-1:0]  hi_q [RANGE_DEPTH];
    logic [DATA_WIDTH-1:0]  val_q;
    logic                   last_q;
    logic [RAW:0]           cnt_q;
    logic [RAW:0]           base_q;
    logic                   hit_q;
    logic [RAW-1:0]         idx_q;
    logic [COUNT_WIDTH-1:0] hit_count_q;
    logic                   done_q;

    logic                   accept;
    logic [RAW:0]           cnt_in;
    logic                   lane_hit;
    logic [RAW-1:0]         lane_idx;
    logic [RAW:0]           lane_addr;
    logic                   last_group;

    assign in_ready  = (state_q == IDLE) && !done_q;
    assign accept    = in_valid && in_ready;
    assign cnt_in    = (cfg_count > DEPTH_W) ? DEPTH_W : cfg_count;
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == RESP);
    assign out_hit   = hit_q;
    assign out_index = idx_q;
    assign hit_count = hit_count_q;
    assign done      = done_q;
    assign last_group = (base_q + LANES_W) >= cnt_q;

    always_ff @(posedge clk) begin
        if (cfg_we && !busy) begin
            lo_q[cfg_addr] <= cfg_lo;
            hi_q[cfg_addr] <= cfg_hi;
        end
    end

    // Walk lanes high to low so the lowest matching index wins.
    always_comb begin
        lane_hit  = 1'b0;
        lane_idx  = '0;
        lane_addr = '0;
        for (int l = LANES - 1; l >= 0; l--) begin
            lane_addr = base_q + (RAW+1)'(l);
            if (lane_addr < cnt_q &&
                lo_q[lane_addr[RAW-1:0]] <= val_q &&
                val_q <= hi_q[lane_addr[RAW-1:0]]) begin
                lane_hit = 1'b1;
                lane_idx = lane_addr[RAW-1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = (cnt_in == '0) ? RESP : SCAN;
            SCAN: if (lane_hit || last_group) state_d = RESP;
            RESP: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            val_q       <= '0;
            last_q      <= 1'b0;
            cnt_q       <= '0;
            base_q      <= '0;
            hit_q       <= 1'b0;
            idx_q       <= '0;
            hit_count_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        val_q  <= in_data;
                        last_q <= in_last;
                        cnt_q  <= cnt_in;
                        base_q <= '0;
                        hit_q  <= 1'b0;
                        idx_q  <= '0;
                    end
                end
                SCAN: begin
                    if (lane_hit) begin
                        hit_q <= 1'b1;
                        idx_q <= lane_idx;
                    end else if (!last_group) begin
                        base_q <= base_q + LANES_W;
                    end
                end
                RESP: begin
                    if (out_ready) begin
                        if (hit_q && hit_count_q != '1)
                            hit_count_q <= hit_count_q + 1'b1;
                        if (last_q)
                            done_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
